// File: rtl/alu_issue_stage.sv
// Decode-to-ALU issue stage: 2-entry skid buffer driving A/B/ALU_opc; optional writeback snoop via ALU_ISSUE_SNOOP_EN.
// Latency: one cycle from push to head when empty; strict FIFO order, entry 0 is head.
// Backpressure: in_ready = count<2 (independent of out_ready); flush and reset discard all entries.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs_addr,
    input  logic [REG_AW-1:0] in_rt_addr,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              in_alu_src,
    input  logic [2:0]        in_alu_opc,
    input  logic [REG_AW-1:0] in_dest,
    input  logic              flush,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [2:0]        ALU_opc,
    output logic [REG_AW-1:0] out_dest
);

    logic [1:0]        r_count;
    logic [DATA_W-1:0] r_a    [2];
    logic [DATA_W-1:0] r_b    [2];
    logic [2:0]        r_opc  [2];
    logic [REG_AW-1:0] r_dest [2];

    logic [DATA_W-1:0] w_a_n    [2];
    logic [DATA_W-1:0] w_b_n    [2];
    logic [2:0]        w_opc_n  [2];
    logic [REG_AW-1:0] w_dest_n [2];
    logic [1:0]        w_count_n;
    logic [1:0]        w_count_pop;
    logic              w_slot;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_imm_ext;
    logic [DATA_W-1:0] w_cap_a;
    logic [DATA_W-1:0] w_cap_b;

    assign in_ready  = rst_n && (r_count < 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_imm_ext = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};

    assign A        = out_valid ? r_a[0]    : '0;
    assign B        = out_valid ? r_b[0]    : '0;
    assign ALU_opc  = out_valid ? r_opc[0]  : 3'd0;
    assign out_dest = out_valid ? r_dest[0] : '0;

    // After a pop the survivor sits at slot 0, so a push lands at the post-pop count.
    assign w_count_pop = r_count - {1'b0, w_pop};
    assign w_slot      = w_count_pop[0];
    assign w_count_n   = flush ? 2'd0 : (w_count_pop + {1'b0, w_push});

`ifdef ALU_ISSUE_SNOOP_EN
    logic [REG_AW-1:0] r_rs   [2];
    logic [REG_AW-1:0] r_rt   [2];
    logic              r_bimm [2];
    logic [REG_AW-1:0] w_rs_n   [2];
    logic [REG_AW-1:0] w_rt_n   [2];
    logic              w_bimm_n [2];
    logic              w_wb_hit;

    // Register 0 is hardwired, so a write to it never forwards.
    assign w_wb_hit = wb_valid && (wb_addr != '0);
    assign w_cap_a  = (w_wb_hit && in_rs_addr == wb_addr) ? wb_data : in_rs_data;
    assign w_cap_b  = in_alu_src ? w_imm_ext :
                      ((w_wb_hit && in_rt_addr == wb_addr) ? wb_data : in_rt_data);
`else
    logic w_unused_wb;
    assign w_unused_wb = ^{wb_valid, wb_addr, wb_data, in_rs_addr, in_rt_addr};
    assign w_cap_a     = in_rs_data;
    assign w_cap_b     = in_alu_src ? w_imm_ext : in_rt_data;
`endif

    always_comb begin
        w_a_n    = r_a;
        w_b_n    = r_b;
        w_opc_n  = r_opc;
        w_dest_n = r_dest;
`ifdef ALU_ISSUE_SNOOP_EN
        w_rs_n   = r_rs;
        w_rt_n   = r_rt;
        w_bimm_n = r_bimm;
        for (int i = 0; i < 2; i++) begin
            if (w_wb_hit && r_rs[i] == wb_addr)
                w_a_n[i] = wb_data;
            if (w_wb_hit && !r_bimm[i] && r_rt[i] == wb_addr)
                w_b_n[i] = wb_data;
        end
`endif
        if (w_pop) begin
            w_a_n[0]    = w_a_n[1];
            w_b_n[0]    = w_b_n[1];
            w_opc_n[0]  = w_opc_n[1];
            w_dest_n[0] = w_dest_n[1];
`ifdef ALU_ISSUE_SNOOP_EN
            w_rs_n[0]   = w_rs_n[1];
            w_rt_n[0]   = w_rt_n[1];
            w_bimm_n[0] = w_bimm_n[1];
`endif
        end
        if (w_push) begin
            w_a_n[w_slot]    = w_cap_a;
            w_b_n[w_slot]    = w_cap_b;
            w_opc_n[w_slot]  = in_alu_opc;
            w_dest_n[w_slot] = in_dest;
`ifdef ALU_ISSUE_SNOOP_EN
            w_rs_n[w_slot]   = in_rs_addr;
            w_rt_n[w_slot]   = in_rt_addr;
            w_bimm_n[w_slot] = in_alu_src;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_a[i]    <= '0;
                r_b[i]    <= '0;
                r_opc[i]  <= 3'd0;
                r_dest[i] <= '0;
`ifdef ALU_ISSUE_SNOOP_EN
                r_rs[i]   <= '0;
                r_rt[i]   <= '0;
                r_bimm[i] <= 1'b0;
`endif
            end
        end else begin
            r_count <= w_count_n;
            for (int i = 0; i < 2; i++) begin
                r_a[i]    <= w_a_n[i];
                r_b[i]    <= w_b_n[i];
                r_opc[i]  <= w_opc_n[i];
                r_dest[i] <= w_dest_n[i];
`ifdef ALU_ISSUE_SNOOP_EN
                r_rs[i]   <= w_rs_n[i];
                r_rt[i]   <= w_rt_n[i];
                r_bimm[i] <= w_bimm_n[i];
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a scoreboard of expected head entries.
module tb_alu_issue_stage;

    localparam int DATA_W = 32;
    localparam int IMM_W  = 16;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_rs_addr;
    logic [REG_AW-1:0] in_rt_addr;
    logic [DATA_W-1:0] in_rs_data;
    logic [DATA_W-1:0] in_rt_data;
    logic [IMM_W-1:0]  in_imm;
    logic              in_alu_src;
    logic [2:0]        in_alu_opc;
    logic [REG_AW-1:0] in_dest;
    logic              flush;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [2:0]        ALU_opc;
    logic [REG_AW-1:0] out_dest;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [2:0]        opc;
        logic [REG_AW-1:0] dest;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.DATA_W(DATA_W), .IMM_W(IMM_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .in_imm(in_imm), .in_alu_src(in_alu_src), .in_alu_opc(in_alu_opc), .in_dest(in_dest),
        .flush(flush), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .A(A), .B(B), .ALU_opc(ALU_opc), .out_dest(out_dest)
    );

    // Scoreboard: expected entries are formed from the decode inputs at the handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_underflow: got A=%h B=%h opc=%0d with no expected entry", A, B, ALU_opc);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    checks++;
                    assert ({A, B, ALU_opc, out_dest} === {e.a, e.b, e.opc, e.dest}) else begin
                        errors++;
                        $error("FAIL sb_head: got A=%h B=%h opc=%0d dest=%0d, want A=%h B=%h opc=%0d dest=%0d",
                               A, B, ALU_opc, out_dest, e.a, e.b, e.opc, e.dest);
                    end
                end
            end
            if (in_valid && in_ready) begin
                e.a    = in_rs_data;
                e.b    = in_alu_src ? {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm} : in_rt_data;
                e.opc  = in_alu_opc;
                e.dest = in_dest;
                sb.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic drive(input logic [DATA_W-1:0] rs, input logic [DATA_W-1:0] rt,
                         input logic [IMM_W-1:0] imm, input logic src, input logic [2:0] opc,
                         input logic [REG_AW-1:0] dest);
        in_valid   = 1'b1;
        in_rs_data = rs;
        in_rt_data = rt;
        in_imm     = imm;
        in_alu_src = src;
        in_alu_opc = opc;
        in_dest    = dest;
    endtask

    initial begin
        logic [DATA_W-1:0] exp_a;
        logic [DATA_W-1:0] exp_b;
        logic              hs;
        logic              done;
        rst_n = 1'b0; in_valid = 1'b0; in_rs_addr = '0; in_rt_addr = '0;
        in_rs_data = '0; in_rt_data = '0; in_imm = '0; in_alu_src = 1'b0;
        in_alu_opc = 3'd0; in_dest = '0; flush = 1'b0; wb_valid = 1'b0;
        wb_addr = '0; wb_data = '0; out_ready = 1'b0;

        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_A", A, 32'd0);
        check("rst_B", B, 32'd0);
        check("rst_opc_dest", {24'd0, ALU_opc, out_dest}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);
        check("rel_empty", {31'd0, out_valid}, 32'd0);

        // Basic push with one-cycle latency.
        out_ready = 1'b1;
        drive(32'd5, 32'd3, 16'h0, 1'b0, 3'b010, 5'd7);
        tick();
        in_valid = 1'b0;
        check("t2_valid", {31'd0, out_valid}, 32'd1);
        check("t2_A", A, 32'd5);
        check("t2_B", B, 32'd3);
        check("t2_opc", {29'd0, ALU_opc}, 32'd2);
        tick();

        // Sign extension; second push coincides with pop of the first.
        drive(32'd1, 32'd0, 16'hFFFC, 1'b1, 3'b000, 5'd1);
        tick();
        check("t3_neg_B", B, 32'hFFFF_FFFC);
        drive(32'd2, 32'd0, 16'h7FFF, 1'b1, 3'b001, 5'd2);
        tick();
        in_valid = 1'b0;
        check("t3_pos_B", B, 32'h0000_7FFF);
        tick();
        check("t3_drained", {31'd0, out_valid}, 32'd0);

        // Fill under backpressure, hold I3 at decode, then drain in order.
        out_ready = 1'b0;
        drive(32'h11, 32'h21, 16'h0, 1'b0, 3'b111, 5'd11);
        tick();
        drive(32'h12, 32'h22, 16'h0, 1'b0, 3'b101, 5'd12);
        tick();
        check("t4_full", {31'd0, in_ready}, 32'd0);
        drive(32'h13, 32'h23, 16'h8000, 1'b1, 3'b110, 5'd13);
        tick();
        tick();
        check("t4_held_ready", {31'd0, in_ready}, 32'd0);
        check("t4_head_A", A, 32'h11);
        check("t4_opc7", {29'd0, ALU_opc}, 32'd7);
        out_ready = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            hs = in_ready;
            tick();
            done = hs;
        end
        in_valid = 1'b0;
        check("t4_i3_accepted", {31'd0, done}, 32'd1);
        for (int k = 0; k < 10 && out_valid; k++) tick();
        check("t4_drain_timeout", {31'd0, out_valid}, 32'd0);
        check("t4_sb_empty", sb.size(), 32'd0);

        // Asynchronous reset while full.
        out_ready = 1'b0;
        drive(32'h31, 32'h41, 16'h0, 1'b0, 3'b011, 5'd3);
        tick();
        drive(32'h32, 32'h42, 16'h0, 1'b0, 3'b100, 5'd4);
        tick();
        in_valid = 1'b0;
        check("t1_full", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("t1_valid", {31'd0, out_valid}, 32'd0);
        check("t1_A", A, 32'd0);
        check("t1_B", B, 32'd0);
        check("t1_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("t1_rel_ready", {31'd0, in_ready}, 32'd1);
        check("t1_rel_empty", {31'd0, out_valid}, 32'd0);
        tick();

        // Writeback snoop on a held entry (no effect when the feature is compiled out).
        in_rs_addr = 5'd8;
        in_rt_addr = 5'd9;
        drive(32'h55, 32'h66, 16'h0, 1'b0, 3'b000, 5'd5);
        tick();
        in_valid = 1'b0;
        check("t5_A_init", A, 32'h55);
        wb_valid = 1'b1; wb_addr = 5'd8; wb_data = 32'h1234;
        tick();
`ifdef ALU_ISSUE_SNOOP_EN
        exp_a = 32'h1234; exp_b = 32'hABCD;
`else
        exp_a = 32'h55;   exp_b = 32'h66;
`endif
        check("t5_A_snoop", A, exp_a);
        wb_addr = 5'd0; wb_data = 32'h9999;
        tick();
        check("t5_A_r0", A, exp_a);
        wb_addr = 5'd9; wb_data = 32'hABCD;
        tick();
        wb_valid = 1'b0;
        check("t5_B_snoop", B, exp_b);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_flushed", {31'd0, out_valid}, 32'd0);

        // Flush beats a simultaneous push.
        drive(32'h71, 32'h72, 16'h0, 1'b0, 3'b001, 5'd6);
        tick();
        check("t6_one", {31'd0, out_valid}, 32'd1);
        drive(32'h73, 32'h74, 16'h0, 1'b0, 3'b010, 5'd7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("t6_valid", {31'd0, out_valid}, 32'd0);
        check("t6_ready", {31'd0, in_ready}, 32'd1);
        check("t6_A", A, 32'd0);
        tick();
        check("t6_stays_empty", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
